// File: rtl/branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// branch_predictor_gshare
//
// Branch direction predictor. It holds a table of saturating counters and a
// global history register (GHR). The table index comes from the PC alone
// (bimodal, GSHARE = 0) or from the PC XOR the GHR (gshare, GSHARE = 1).
// The GHR is kept up to date in both modes.
//
// Prediction is combinational and has zero latency. Training happens at
// branch resolution, using the table index that was captured at guess time
// and carried down the pipeline. The GHR is only updated at resolution, so it
// holds committed outcomes only. The block also keeps saturating statistics
// counters for branches and mispredicts.
//
// Ports
//   clk              in   clock
//   reset            in   asynchronous, active-high reset
//   pc_guess         in   PC of the instruction in IF
//   is_br_guess      in   the IF instruction is a conditional branch
//   br_pred_taken    out  predicted direction for pc_guess
//   idx_guess        out  table index used for this guess (carried to check)
//   is_br_check      in   a branch resolves this cycle
//   idx_check        in   idx_guess captured when that branch was predicted
//   br_taken_check   in   actual outcome of the resolving branch
//   pred_taken_check in   br_pred_taken captured when that branch was predicted
//   br_mispredict    out  the resolving branch was mispredicted
//   ghr              out  current global history (debug)
//   stat_branches    out  count of resolved branches (saturating)
//   stat_mispredicts out  count of mispredicted branches (saturating)
// -----------------------------------------------------------------------------
module branch_predictor_gshare #(
   parameter  int PC_WIDTH   = 32,
   parameter  int LINES      = 128,
   parameter  int CNT_WIDTH  = 2,
   parameter  int GHR_WIDTH  = 7,
   parameter  int GSHARE     = 1,
   parameter  int STAT_WIDTH = 32,
   localparam int IDX_W      = $clog2(LINES)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [PC_WIDTH-1:0]   pc_guess,
   input  logic                  is_br_guess,
   output logic                  br_pred_taken,
   output logic [IDX_W-1:0]      idx_guess,
   input  logic                  is_br_check,
   input  logic [IDX_W-1:0]      idx_check,
   input  logic                  br_taken_check,
   input  logic                  pred_taken_check,
   output logic                  br_mispredict,
   output logic [GHR_WIDTH-1:0]  ghr,
   output logic [STAT_WIDTH-1:0] stat_branches,
   output logic [STAT_WIDTH-1:0] stat_mispredicts
);

   // Weakly-not-taken reset value: 2^(CNT_WIDTH-1) - 1, which is 0 for 1-bit counters.
   localparam logic [CNT_WIDTH-1:0]  CNT_WNT  = CNT_WIDTH'((2 ** (CNT_WIDTH - 1)) - 1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

   // Move a direction counter one step toward the outcome, clamping at both ends.
   function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] c,
                                                     input logic               up);
      logic [CNT_WIDTH-1:0] r;
      r = c;
      if (up) begin
         if (c != CNT_MAX) r = c + CNT_WIDTH'(1);
      end else begin
         if (c != '0) r = c - CNT_WIDTH'(1);
      end
      return r;
   endfunction

   // Increment a statistics counter. It sticks at all-ones and never wraps.
   function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] s);
      return (s == STAT_MAX) ? s : s + STAT_WIDTH'(1);
   endfunction

   logic [CNT_WIDTH-1:0] cnt_tbl [LINES];
   logic [GHR_WIDTH-1:0] ghr_r;
   logic [GHR_WIDTH-1:0] ghr_next;
   logic [IDX_W-1:0]     pc_idx;
   logic [CNT_WIDTH-1:0] guess_cnt;
   logic                 unused_pc_bits;

   // Guess: index generation and table read (combinational)
   // Word-aligned PC: bits [1:0] and the bits above the index do not select an entry.
   assign pc_idx         = pc_guess[IDX_W+1:2];
   assign unused_pc_bits = ^{pc_guess[PC_WIDTH-1:IDX_W+2], pc_guess[1:0]};

   generate
      if (GSHARE != 0) begin : g_gshare
         assign idx_guess = pc_idx ^ IDX_W'(ghr_r);
      end else begin : g_bimodal
         assign idx_guess = pc_idx;
      end
   endgenerate

   // The read sees the stored value. A same-cycle update to this entry is not
   // bypassed, so the guess returns the pre-update counter.
   assign guess_cnt     = cnt_tbl[idx_guess];
   assign br_pred_taken = is_br_guess & guess_cnt[CNT_WIDTH-1];

   // Check: mispredict detection and history shift
   assign br_mispredict = is_br_check & (br_taken_check ^ pred_taken_check);

   // Shift in the outcome at the LSB. The cast keeps the low GHR_WIDTH bits,
   // so a 1-bit history holds just the latest outcome.
   assign ghr_next = GHR_WIDTH'({ghr_r, br_taken_check});
   assign ghr      = ghr_r;

   // State: counter table, history and statistics
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < LINES; i++) begin
            cnt_tbl[i] <= CNT_WNT;
         end
      end else if (is_br_check) begin
         cnt_tbl[idx_check] <= cnt_step(cnt_tbl[idx_check], br_taken_check);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ghr_r            <= '0;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (is_br_check) begin
            ghr_r         <= ghr_next;
            stat_branches <= stat_inc(stat_branches);
         end
         if (br_mispredict) begin
            stat_mispredicts <= stat_inc(stat_mispredicts);
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_gshare
//
// Two predictors are driven with identical inputs: a gshare one with default
// sizes and a bimodal one with 4-bit statistics counters. Updates use
// idx_check directly, so both tables and both GHRs evolve the same way. Only
// idx_guess (and hence the prediction) and the statistics width differ.
// -----------------------------------------------------------------------------
module tb_branch_predictor_gshare;

   logic        clk;
   logic        reset;
   logic [31:0] pc_guess;
   logic        is_br_guess;
   logic        is_br_check;
   logic [6:0]  idx_check;
   logic        br_taken_check;
   logic        pred_taken_check;

   logic        g_pred, b_pred;
   logic [6:0]  g_idx, b_idx;
   logic        g_mp, b_mp;
   logic [6:0]  g_ghr, b_ghr;
   logic [31:0] g_nbr, g_nmp;
   logic [3:0]  b_nbr, b_nmp;

   int n_cmp = 0;
   int n_err = 0;

   branch_predictor_gshare #(
      .PC_WIDTH(32), .LINES(128), .CNT_WIDTH(2), .GHR_WIDTH(7),
      .GSHARE(1), .STAT_WIDTH(32)
   ) u_gsh (
      .clk(clk), .reset(reset), .pc_guess(pc_guess), .is_br_guess(is_br_guess),
      .br_pred_taken(g_pred), .idx_guess(g_idx), .is_br_check(is_br_check),
      .idx_check(idx_check), .br_taken_check(br_taken_check),
      .pred_taken_check(pred_taken_check), .br_mispredict(g_mp), .ghr(g_ghr),
      .stat_branches(g_nbr), .stat_mispredicts(g_nmp)
   );

   branch_predictor_gshare #(
      .PC_WIDTH(32), .LINES(128), .CNT_WIDTH(2), .GHR_WIDTH(7),
      .GSHARE(0), .STAT_WIDTH(4)
   ) u_bim (
      .clk(clk), .reset(reset), .pc_guess(pc_guess), .is_br_guess(is_br_guess),
      .br_pred_taken(b_pred), .idx_guess(b_idx), .is_br_check(is_br_check),
      .idx_check(idx_check), .br_taken_check(br_taken_check),
      .pred_taken_check(pred_taken_check), .br_mispredict(b_mp), .ghr(b_ghr),
      .stat_branches(b_nbr), .stat_mispredicts(b_nmp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a resolving branch. The caller may check combinational outputs afterwards.
   task automatic put_check(input logic [6:0] idx, input logic taken, input logic pred);
      is_br_check      = 1'b1;
      idx_check        = idx;
      br_taken_check   = taken;
      pred_taken_check = pred;
      #1;
   endtask

   // Cross one rising edge, then drop is_br_check. Returns 2 time units after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      is_br_check = 1'b0;
      #1;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
   endtask

   task automatic resolve(input logic [6:0] idx, input logic taken);
      put_check(idx, taken, taken);
      tick();
   endtask

   initial begin
      reset            = 1'b1;
      pc_guess         = '0;
      is_br_guess      = 1'b0;
      is_br_check      = 1'b0;
      idx_check        = '0;
      br_taken_check   = 1'b0;
      pred_taken_check = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;

      // ---- 1: reset state ----
      pc_guess    = 32'h100;
      is_br_guess = 1'b0;
      #1;
      check_val("rst_pred_noguess", {31'd0, g_pred}, 32'd0);
      is_br_guess = 1'b1;
      #1;
      check_val("rst_pred", {31'd0, g_pred}, 32'd0);
      check_val("rst_idx_gsh", {25'd0, g_idx}, 32'h40);
      check_val("rst_idx_bim", {25'd0, b_idx}, 32'h40);
      check_val("rst_ghr", {25'd0, g_ghr}, 32'd0);
      check_val("rst_nbr", g_nbr, 32'd0);
      check_val("rst_nmp", g_nmp, 32'd0);
      check_val("rst_mp", {31'd0, g_mp}, 32'd0);
      reset = 1'b0;
      #1;

      // ---- 2: bimodal training on idx 0x10 (pc 0x40) ----
      pc_guess = 32'h40;
      #1;
      check_val("bim_idx", {25'd0, b_idx}, 32'h10);
      check_val("bim_pred_init", {31'd0, b_pred}, 32'd0);
      resolve(7'h10, 1'b1);   // 1 -> 2
      check_val("bim_pred_t1", {31'd0, b_pred}, 32'd1);
      resolve(7'h10, 1'b1);   // 2 -> 3
      check_val("bim_pred_t2", {31'd0, b_pred}, 32'd1);
      resolve(7'h10, 1'b1);   // 3 -> 3 (saturated)
      check_val("bim_pred_t3", {31'd0, b_pred}, 32'd1);
      resolve(7'h10, 1'b0);   // 3 -> 2
      check_val("bim_pred_n1", {31'd0, b_pred}, 32'd1);
      resolve(7'h10, 1'b0);   // 2 -> 1
      check_val("bim_pred_n2", {31'd0, b_pred}, 32'd0);
      check_val("bim_ghr", {25'd0, g_ghr}, 32'h1C);
      check_val("bim_nbr", g_nbr, 32'd5);

      // ---- 3: gshare indexing ----
      pulse_reset();
      for (int i = 0; i < 4; i++) resolve(7'h05, 1'b1);
      check_val("gsh_ghr_0f", {25'd0, g_ghr}, 32'h0F);
      check_val("gsh_ghr_bim", {25'd0, b_ghr}, 32'h0F);
      pc_guess = 32'h100;
      #1;
      check_val("gsh_idx_4f", {25'd0, g_idx}, 32'h4F);
      check_val("gsh_idx_bim40", {25'd0, b_idx}, 32'h40);
      check_val("gsh_pred_cold", {31'd0, g_pred}, 32'd0);
      resolve(7'h4F, 1'b1);   // entry 0x4F: 1 -> 2, ghr -> 0x1F
      check_val("gsh_ghr_1f", {25'd0, g_ghr}, 32'h1F);
      for (int i = 0; i < 3; i++) resolve(7'h05, 1'b0);
      for (int i = 0; i < 4; i++) resolve(7'h05, 1'b1);
      check_val("gsh_ghr_back", {25'd0, g_ghr}, 32'h0F);
      check_val("gsh_pred_warm", {31'd0, g_pred}, 32'd1);
      check_val("gsh_pred_bim_cold", {31'd0, b_pred}, 32'd0);

      // ---- 4: mispredict counting ----
      pulse_reset();
      is_br_guess = 1'b0;
      put_check(7'h30, 1'b1, 1'b0);
      check_val("mp_c1", {31'd0, g_mp}, 32'd1);
      tick();
      put_check(7'h30, 1'b1, 1'b1);
      check_val("mp_c2", {31'd0, g_mp}, 32'd0);
      tick();
      put_check(7'h30, 1'b0, 1'b1);
      check_val("mp_c3", {31'd0, b_mp}, 32'd1);
      tick();
      put_check(7'h30, 1'b0, 1'b0);
      check_val("mp_c4", {31'd0, b_mp}, 32'd0);
      tick();
      put_check(7'h30, 1'b1, 1'b0);
      check_val("mp_c5", {31'd0, g_mp}, 32'd1);
      tick();
      br_taken_check   = 1'b1;
      pred_taken_check = 1'b0;
      #1;
      check_val("mp_gated", {31'd0, g_mp}, 32'd0);
      check_val("mp_nbr", g_nbr, 32'd5);
      check_val("mp_nmp", g_nmp, 32'd3);
      check_val("mp_nmp_bim", {28'd0, b_nmp}, 32'd3);
      check_val("mp_ghr", {25'd0, g_ghr}, 32'h19);

      // ---- 5: same-cycle guess and check on idx 0x22 (pc 0x88) ----
      pc_guess    = 32'h88;
      is_br_guess = 1'b1;
      put_check(7'h22, 1'b1, 1'b0);
      check_val("same_idx", {25'd0, b_idx}, 32'h22);
      check_val("same_pred_pre", {31'd0, b_pred}, 32'd0);
      check_val("same_gidx_preghr", {25'd0, g_idx}, 32'h3B);
      tick();
      check_val("same_pred_post", {31'd0, b_pred}, 32'd1);

      // ---- 6: statistics saturation, counter floor, async reset ----
      for (int i = 0; i < 14; i++) resolve(7'h60, 1'b0);
      check_val("sat_nbr_bim", {28'd0, b_nbr}, 32'd15);
      check_val("sat_nbr_gsh", g_nbr, 32'd20);
      check_val("sat_nmp_bim", {28'd0, b_nmp}, 32'd4);
      pc_guess = 32'h180;
      #1;
      check_val("floor_pred", {31'd0, b_pred}, 32'd0);
      pc_guess = 32'h88;
      #1;
      check_val("pre_rst_pred", {31'd0, b_pred}, 32'd1);
      reset = 1'b1;
      #1;
      check_val("arst_pred", {31'd0, b_pred}, 32'd0);
      check_val("arst_ghr", {25'd0, g_ghr}, 32'd0);
      check_val("arst_nbr_gsh", g_nbr, 32'd0);
      check_val("arst_nbr_bim", {28'd0, b_nbr}, 32'd0);
      check_val("arst_nmp_gsh", g_nmp, 32'd0);
      reset = 1'b0;
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised direction predictor with a global history register (GHR) and a table of N-bit saturating counters.
- Operates in bimodal mode (index from PC only) or gshare mode (PC XOR GHR).
- The IF stage reads predictions. The resolving stage writes outcomes back using the table index captured at guess time and carried down the pipe.
- Also keeps branch and mispredict statistics counters for performance measurement.

Parameters:
- PC_WIDTH, 32, PC width in bits.
- LINES, 128, counter table entries. Must be a power of 2, ≥ 2. IDX_W = $clog2(LINES).
- CNT_WIDTH, 2, saturating counter width. Must be ≥ 1.
- GHR_WIDTH, 7, global history length. Must be 1 ≤ GHR_WIDTH ≤ IDX_W.
- GSHARE, 1, 1 = gshare indexing, 0 = bimodal indexing. The GHR is maintained in both modes.
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pc_guess  input  PC_WIDTH  PC of the instruction in IF.
- is_br_guess  input  1  the IF instruction is a conditional branch.
- br_pred_taken  output  1  prediction for pc_guess.
- idx_guess  output  IDX_W  table index used for this guess. The pipeline carries it to the check stage.
- is_br_check  input  1  a branch resolves this cycle.
- idx_check  input  IDX_W  idx_guess captured when that branch was predicted.
- br_taken_check  input  1  actual outcome.
- pred_taken_check  input  1  br_pred_taken captured when that branch was predicted.
- br_mispredict  output  1  resolving branch was mispredicted.
- ghr  output  GHR_WIDTH  current global history, for debug.
- stat_branches  output  STAT_WIDTH  resolved branch count.
- stat_mispredicts  output  STAT_WIDTH  mispredicted branch count.

Behaviour:
- Reset (async, active-high):
  - every table counter is set to weakly-not-taken, W = 2^(CNT_WIDTH-1) - 1 (CNT_WIDTH = 1 gives 0);
  - GHR = 0;
  - both statistics counters = 0.
- Outputs on reset:
  - br_mispredict = 0 while is_br_check = 0;
  - br_pred_taken = 0 while is_br_guess = 0;
  - ghr = 0.
- Deassertion of reset must not be sampled mid-write. Writes occur only on rising clk edges while reset = 0.
- Index computation (combinational):
  - P = pc_guess[IDX_W+1:2].
  - GSHARE = 1: idx_guess = P XOR {zeros, ghr}, with the GHR zero-extended to IDX_W.
  - GSHARE = 0: idx_guess = P.
- Prediction (combinational, zero latency):
  - br_pred_taken = is_br_guess AND MSB(table[idx_guess]).
  - idx_guess is driven regardless of is_br_guess.
- Update (rising clk edge, when is_br_check = 1):
  - If br_taken_check = 1, table[idx_check] increments, saturating at 2^CNT_WIDTH - 1.
  - If br_taken_check = 0, table[idx_check] decrements, saturating at 0.
  - GHR becomes {ghr[GHR_WIDTH-2:0], br_taken_check}, i.e. shift left and insert the outcome at the LSB. For GHR_WIDTH = 1 the GHR is just br_taken_check.
  - The GHR is updated non-speculatively, at check time only.
- Statistics counters:
  - stat_branches increments on each is_br_check cycle.
  - stat_mispredicts increments when br_mispredict = 1.
  - Both saturate at all-ones and never wrap.
- br_mispredict = is_br_check AND (br_taken_check XOR pred_taken_check). Combinational.
- Simultaneous guess and check to the same index in one cycle:
  - the guess returns the pre-update value (no bypass);
  - idx_guess uses the pre-update GHR.
- No update occurs when is_br_check = 0. idx_check and the taken inputs are then don't-care.

Test Plan:
1. Reset, then is_br_guess = 1 with pc_guess = 0x100 -> br_pred_taken = 0, idx_guess = 0x40, ghr = 0, both stats = 0.
2. Bimodal, CNT_WIDTH = 2. Check idx 0x10 taken 3×:
   - counter goes 1→2→3→3;
   - prediction for pc = 0x40 becomes 1 after the first update;
   - then 2 not-taken checks bring the counter to 1 and the prediction back to 0.
3. Gshare. Four taken checks:
   - ghr = 0x0F;
   - pc_guess = 0x100 gives idx_guess = 0x40 ^ 0x0F = 0x4F;
   - a check at idx 0x4F with taken, followed by a guess at pc 0x100 once ghr again equals 0x0F, predicts taken.
4. Mispredict counting. Sequence of 5 checks with (taken, pred) = (1,0), (1,1), (0,1), (0,0), (1,0):
   - br_mispredict pulses on checks 1, 3 and 5;
   - stat_branches = 5, stat_mispredicts = 3.
5. Same-cycle guess and check on idx 0x22, with the counter at 1 and taken = 1:
   - br_pred_taken = 0 in that cycle;
   - the next-cycle guess predicts 1.
6. Saturation and reset:
   - with STAT_WIDTH = 4, 20 checks leave stat_branches = 15;
   - assert reset asynchronously between clock edges -> stats, GHR and counters clear immediately, with no clock edge required.
